// File: rtl/hdmi_pkg.sv
`default_nettype none
//==============================================================================
// Module   : hdmi_pkg
// Brief    : Shared state encoding and default timing constants for the
//            PLL reset sequencer.
// Revision : 1.0 - initial release
//==============================================================================
package hdmi_pkg;

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAULT     = 3'd4
   } seq_state_t;

   // Defaults assume a 12 MHz reference clock.
   localparam int unsigned c_def_rst_cycles    = 16;
   localparam int unsigned c_def_lock_timeout  = 1200;
   localparam int unsigned c_def_stable_cycles = 256;
   localparam int unsigned c_def_max_retries   = 3;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
//==============================================================================
// Module   : sync_2ff
// Brief    : Single-bit two-flop synchronizer, asynchronous active-low reset.
// Revision : 1.0 - initial release
//==============================================================================
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : pll_reset_sequencer
// Brief    : Pulses PLL reset, waits for a stable lock with bounded retries and
//            releases the video-domain reset only while the PLL is locked.
// Revision : 1.0 - initial release
//==============================================================================
module pll_reset_sequencer
   import hdmi_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = c_def_rst_cycles,
   parameter int unsigned LOCK_TIMEOUT  = c_def_lock_timeout,
   parameter int unsigned STABLE_CYCLES = c_def_stable_cycles,
   parameter int unsigned MAX_RETRIES   = c_def_max_retries
) (
   input  logic       clock_in,
   input  logic       reset_n,
   input  logic       locked,
   input  logic       restart,
   output logic       pll_reset,
   output logic       video_reset_n,
   output logic       ready,
   output logic       fault,
   output logic       lock_lost,
   output logic [1:0] retries
);

   localparam int unsigned c_cnt_max = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam int unsigned c_cnt_w   = $clog2(c_cnt_max + 1);
   localparam int unsigned c_tmo_w   = $clog2(LOCK_TIMEOUT + 1);

   localparam logic [c_cnt_w-1:0] c_rst_last    = c_cnt_w'(RST_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(STABLE_CYCLES - 1);
   localparam logic [c_tmo_w-1:0] c_tmo_last    = c_tmo_w'(LOCK_TIMEOUT - 1);
   localparam logic [1:0]         c_max_ret     = (MAX_RETRIES > 3) ? 2'd3 : 2'(MAX_RETRIES);

   seq_state_t         r_state;
   seq_state_t         w_next_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [c_cnt_w-1:0] w_cnt_nxt;
   logic [c_tmo_w-1:0] r_tmo;
   logic [c_tmo_w-1:0] w_tmo_nxt;
   logic [1:0]         r_retries;
   logic [1:0]         w_retries_nxt;
   logic [1:0]         w_retries_inc;
   logic               r_lock_lost;
   logic               w_lock_lost_nxt;
   logic               w_fail;
   logic               w_locked_s;

   logic r_pll_reset;
   logic r_video_reset_n;
   logic r_ready;
   logic r_fault;

   sync_2ff u_lock_sync (
      .clk   (clock_in),
      .rst_n (reset_n),
      .i_d   (locked),
      .o_q   (w_locked_s)
   );

   assign w_retries_inc = (r_retries == c_max_ret) ? r_retries : r_retries + 2'd1;

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_PLL_RST;
         r_cnt       <= '0;
         r_tmo       <= '0;
         r_retries   <= 2'd0;
         r_lock_lost <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_cnt       <= w_cnt_nxt;
         r_tmo       <= w_tmo_nxt;
         r_retries   <= w_retries_nxt;
         r_lock_lost <= w_lock_lost_nxt;
      end
   end

   // r_cnt times the current phase; r_tmo bounds WAIT_LOCK+STABLE of one attempt.
   always_comb begin
      w_next_state    = r_state;
      w_cnt_nxt       = r_cnt;
      w_tmo_nxt       = r_tmo;
      w_retries_nxt   = r_retries;
      w_lock_lost_nxt = r_lock_lost;
      w_fail          = 1'b0;

      case (r_state)
         ST_PLL_RST: begin
            if (r_cnt == c_rst_last) begin
               w_next_state = ST_WAIT_LOCK;
               w_cnt_nxt    = '0;
               w_tmo_nxt    = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end

         ST_WAIT_LOCK: begin
            if (r_tmo == c_tmo_last) begin
               w_fail = 1'b1;
            end else begin
               w_tmo_nxt = r_tmo + 1'b1;
               if (w_locked_s) begin
                  w_next_state = ST_STABLE;
                  w_cnt_nxt    = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end

         ST_STABLE: begin
            if (w_locked_s && (r_cnt == c_stable_last)) begin
               w_next_state = ST_RUN;
               w_cnt_nxt    = '0;
            end else if (r_tmo == c_tmo_last) begin
               w_fail = 1'b1;
            end else if (!w_locked_s) begin
               w_next_state = ST_WAIT_LOCK;
               w_cnt_nxt    = '0;
               w_tmo_nxt    = r_tmo + 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
               w_tmo_nxt = r_tmo + 1'b1;
            end
         end

         ST_RUN: begin
            if (!w_locked_s) begin
               w_next_state    = ST_PLL_RST;
               w_cnt_nxt       = '0;
               w_lock_lost_nxt = 1'b1;
               w_retries_nxt   = 2'd0;
            end
         end

         ST_FAULT: begin
            w_next_state = ST_FAULT;
         end

         default: begin
            w_next_state = ST_PLL_RST;
            w_cnt_nxt    = '0;
         end
      endcase

      if (w_fail) begin
         w_retries_nxt = w_retries_inc;
         w_cnt_nxt     = '0;
         w_next_state  = (w_retries_inc == c_max_ret) ? ST_FAULT : ST_PLL_RST;
      end

      // Restart overrides every other transition decided above.
      if (restart) begin
         w_next_state    = ST_PLL_RST;
         w_cnt_nxt       = '0;
         w_tmo_nxt       = '0;
         w_retries_nxt   = 2'd0;
         w_lock_lost_nxt = 1'b0;
      end
   end

   // Decoded from the next state so the outputs switch on the same edge as the state.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         r_pll_reset     <= 1'b1;
         r_video_reset_n <= 1'b0;
         r_ready         <= 1'b0;
         r_fault         <= 1'b0;
      end else begin
         r_pll_reset     <= (w_next_state == ST_PLL_RST) || (w_next_state == ST_FAULT);
         r_video_reset_n <= (w_next_state == ST_RUN);
         r_ready         <= (w_next_state == ST_RUN);
         r_fault         <= (w_next_state == ST_FAULT);
      end
   end

   assign pll_reset     = r_pll_reset;
   assign video_reset_n = r_video_reset_n;
   assign ready         = r_ready;
   assign fault         = r_fault;
   assign lock_lost     = r_lock_lost;
   assign retries       = r_retries;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_pll_reset_sequencer
// Brief    : Directed self-checking bench for pll_reset_sequencer.
// Revision : 1.0 - initial release
//==============================================================================
module tb_pll_reset_sequencer;

   logic       clock_in = 1'b0;
   logic       reset_n  = 1'b0;
   logic       locked   = 1'b0;
   logic       restart  = 1'b0;
   logic       pll_reset;
   logic       video_reset_n;
   logic       ready;
   logic       fault;
   logic       lock_lost;
   logic [1:0] retries;

   int cyc      = 0;
   int n_checks = 0;
   int n_fail   = 0;

   pll_reset_sequencer dut (
      .clock_in      (clock_in),
      .reset_n       (reset_n),
      .locked        (locked),
      .restart       (restart),
      .pll_reset     (pll_reset),
      .video_reset_n (video_reset_n),
      .ready         (ready),
      .fault         (fault),
      .lock_lost     (lock_lost),
      .retries       (retries)
   );

   always #5 clock_in = ~clock_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   // Advance to 1 ns after rising edge n (edge 1 is the first after reset release).
   task automatic run_to(input int n);
      while (cyc < n) begin
         @(posedge clock_in);
         cyc++;
      end
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " pll_reset"},     32'(pll_reset),     32'd1);
      chk({tag, " video_reset_n"}, 32'(video_reset_n), 32'd0);
      chk({tag, " ready"},         32'(ready),         32'd0);
      chk({tag, " fault"},         32'(fault),         32'd0);
      chk({tag, " lock_lost"},     32'(lock_lost),     32'd0);
      chk({tag, " retries"},       32'(retries),       32'd0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clock_in);
      #1;
      chk_reset_outputs("in_reset");
      reset_n = 1'b1;
      cyc     = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Lock at cycle 40, RUN, lock drop, relock, restart during lock loss.
      locked = 1'b0;
      do_reset();
      run_to(1);   chk("A pll_rst_1",  32'(pll_reset), 32'd1);
      run_to(15);  chk("A pll_rst_15", 32'(pll_reset), 32'd1);
      run_to(16);  chk("A pll_rel_16", 32'(pll_reset), 32'd0);
      run_to(39);  locked = 1'b1;
      run_to(297); chk("A ready_297",  32'(ready), 32'd0);
                   chk("A vrst_297",   32'(video_reset_n), 32'd0);
      run_to(298); chk("A ready_298",  32'(ready), 32'd1);
                   chk("A vrst_298",   32'(video_reset_n), 32'd1);
                   chk("A retries",    32'(retries), 32'd0);
                   chk("A pll_run",    32'(pll_reset), 32'd0);
      run_to(309); locked = 1'b0;
      run_to(311); chk("A ready_311",  32'(ready), 32'd1);
                   chk("A lost_311",   32'(lock_lost), 32'd0);
      run_to(312); chk("A ready_drop", 32'(ready), 32'd0);
                   chk("A vrst_drop",  32'(video_reset_n), 32'd0);
                   chk("A lost_drop",  32'(lock_lost), 32'd1);
                   chk("A pll_drop",   32'(pll_reset), 32'd1);
      run_to(314); locked = 1'b1;
      run_to(327); chk("A pll_327",    32'(pll_reset), 32'd1);
      run_to(328); chk("A pll_328",    32'(pll_reset), 32'd0);
      run_to(584); chk("A ready_584",  32'(ready), 32'd0);
      run_to(585); chk("A ready_585",  32'(ready), 32'd1);
                   chk("A lost_keep",  32'(lock_lost), 32'd1);
      run_to(589); locked = 1'b0;
      run_to(591); restart = 1'b1;
      run_to(592); restart = 1'b0;
                   chk("A rs_pll",     32'(pll_reset), 32'd1);
                   chk("A rs_lost",    32'(lock_lost), 32'd0);
                   chk("A rs_retries", 32'(retries), 32'd0);
                   chk("A rs_ready",   32'(ready), 32'd0);
      run_to(607); chk("A rs_pll_607", 32'(pll_reset), 32'd1);
      run_to(608); chk("A rs_pll_608", 32'(pll_reset), 32'd0);

      // One-cycle lock glitch at stable count 100.
      locked = 1'b0;
      do_reset();
      run_to(39);  locked = 1'b1;
      run_to(142); locked = 1'b0;
      run_to(143); locked = 1'b1;
      run_to(150); chk("G pll_150",    32'(pll_reset), 32'd0);
      run_to(298); chk("G ready_298",  32'(ready), 32'd0);
      run_to(401); chk("G ready_401",  32'(ready), 32'd0);
      run_to(402); chk("G ready_402",  32'(ready), 32'd1);
                   chk("G retries",    32'(retries), 32'd0);

      // No lock: three timed-out attempts then FAULT, then restart.
      locked = 1'b0;
      do_reset();
      run_to(1215); chk("B ret_1215",  32'(retries), 32'd0);
                    chk("B pll_1215",  32'(pll_reset), 32'd0);
      run_to(1216); chk("B ret_1216",  32'(retries), 32'd1);
                    chk("B pll_1216",  32'(pll_reset), 32'd1);
                    chk("B flt_1216",  32'(fault), 32'd0);
      run_to(2431); chk("B ret_2431",  32'(retries), 32'd1);
      run_to(2432); chk("B ret_2432",  32'(retries), 32'd2);
      run_to(3647); chk("B flt_3647",  32'(fault), 32'd0);
                    chk("B pll_3647",  32'(pll_reset), 32'd0);
      run_to(3648); chk("B flt_3648",  32'(fault), 32'd1);
                    chk("B ret_3648",  32'(retries), 32'd3);
                    chk("B pll_3648",  32'(pll_reset), 32'd1);
                    chk("B vrst_3648", 32'(video_reset_n), 32'd0);
                    chk("B rdy_3648",  32'(ready), 32'd0);
      run_to(5000); chk("B flt_hold",  32'(fault), 32'd1);
                    chk("B pll_hold",  32'(pll_reset), 32'd1);
                    chk("B ret_sat",   32'(retries), 32'd3);
      run_to(5009); restart = 1'b1;
      run_to(5010); restart = 1'b0;
                    chk("B rs_fault",  32'(fault), 32'd0);
                    chk("B rs_ret",    32'(retries), 32'd0);
                    chk("B rs_pll",    32'(pll_reset), 32'd1);
      run_to(5025); chk("B rs_pll_15", 32'(pll_reset), 32'd1);
      run_to(5026); chk("B rs_pll_16", 32'(pll_reset), 32'd0);

      // Asynchronous reset in the middle of WAIT_LOCK with retries pending.
      run_to(6226); chk("C ret_6226",  32'(retries), 32'd1);
      run_to(6300); chk("C pll_6300",  32'(pll_reset), 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("C async");
      @(posedge clock_in);
      #1;
      reset_n = 1'b1;
      cyc     = 0;
      run_to(15);  chk("C pll_15",     32'(pll_reset), 32'd1);
      run_to(16);  chk("C pll_16",     32'(pll_reset), 32'd0);
                   chk("C retries",    32'(retries), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
